// File: rtl/vram_readout_arbiter_pkg.sv
// rtl/vram_readout_arbiter_pkg.sv - shared video constants for the VRAM readout arbiter
//
// Purpose: character-period phase numbering, default text geometry and the
// readout state type shared by the arbiter and its address generator.
// Ports: none (package).

package vram_readout_arbiter_pkg;

  // Phases of the 8-clock character period, as seen on readoutCount.
  localparam logic [2:0] PH_HOST_A    = 3'd0;
  localparam logic [2:0] PH_CHAR_ADDR = 3'd2;
  localparam logic [2:0] PH_CHAR_DATA = 3'd3;
  localparam logic [2:0] PH_HOST_B    = 3'd4;
  localparam logic [2:0] PH_ATTR_ADDR = 3'd6;
  localparam logic [2:0] PH_ATTR_DATA = 3'd7;
  localparam logic [2:0] PH_IDLE      = 3'd7;

  // Default text geometry: 80x30 cells, 16 scanlines per cell.
  localparam int DEF_COLS          = 80;
  localparam int DEF_ROWS          = 30;
  localparam int DEF_LINES_PER_ROW = 16;
  localparam int DEF_ADDR_W        = 13;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_READOUT = 1'b1
  } readoutState_t;

endpackage

// File: rtl/vram_readout_arbiter_text_addr_gen.sv
// rtl/vram_readout_arbiter_text_addr_gen.sv - character-cell VRAM address generator
//
// Purpose: tracks the current column, scanline-within-row and row base, and
// produces the character and attribute byte addresses for the current cell.
// Ports:
//   clk, nrst      clock, synchronous active-low reset
//   lineGo         accepted start of a scanline readout (arbiter was idle)
//   frameStart     top-of-frame pulse; clears lineRow/rowBase
//   colStep        last cycle of a character period while reading out
//   lastCol        current column is the final one of the line
//   charAddr       lineBase + 2*col
//   attrAddr       lineBase + 2*col + 1

module text_addr_gen
  import vram_readout_arbiter_pkg::*;
#(
  parameter int COLS          = DEF_COLS,
  parameter int ROWS          = DEF_ROWS,
  parameter int LINES_PER_ROW = DEF_LINES_PER_ROW,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              lineGo,
  input  logic              frameStart,
  input  logic              colStep,
  output logic              lastCol,
  output logic [ADDR_W-1:0] charAddr,
  output logic [ADDR_W-1:0] attrAddr
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LROW_W = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;

  localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(COLS - 1);
  localparam logic [LROW_W-1:0] LAST_LINE     = LROW_W'(LINES_PER_ROW - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE    = ADDR_W'(2 * COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(2 * COLS * (ROWS - 1));

  logic [COL_W-1:0]  col;
  logic [LROW_W-1:0] lineRow;
  logic [ADDR_W-1:0] rowBase;
  logic [ADDR_W-1:0] lineBase;

  assign lastCol  = (col == LAST_COL);
  assign charAddr = lineBase + ADDR_W'({col, 1'b0});
  assign attrAddr = charAddr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      col      <= '0;
      lineRow  <= '0;
      rowBase  <= '0;
      lineBase <= '0;
    end else begin
      // lineBase is latched once per line so a mid-line frameStart cannot
      // disturb the addresses of the line already being drawn.
      if (lineGo) begin
        col      <= '0;
        lineBase <= frameStart ? '0 : rowBase;
      end else if (colStep) begin
        col <= lastCol ? '0 : col + COL_W'(1);
      end

      // frameStart takes priority over the end-of-line row advance.
      if (frameStart) begin
        lineRow <= '0;
        rowBase <= '0;
      end else if (colStep && lastCol) begin
        if (lineRow == LAST_LINE) begin
          lineRow <= '0;
          rowBase <= (rowBase == LAST_ROW_BASE) ? '0 : rowBase + ROW_STRIDE;
        end else begin
          lineRow <= lineRow + LROW_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vram_readout_arbiter.sv
// rtl/vram_readout_arbiter.sv - text-mode VRAM readout sequencer and host arbiter
//
// Purpose: runs the COLS*8-cycle readout window for each scanline, places
// character/attribute fetches at phases 2 and 6 of every character period,
// and grants single-cycle host accesses at phases 0 and 4 and whenever idle.
// Ports:
//   clk, nrst                  clock, synchronous active-low reset
//   lineStart, frameStart      scanline / frame timing pulses
//   readoutCount, active       phase and window flag for the pixel generator
//   vramAddr/vramWe/vramWrData registered single-port VRAM controls
//   vramRdData                 VRAM read data, one cycle after address
//   cpuReq/cpuWe/cpuAddr/cpuWrData  host request, held until cpuAck
//   cpuAck, cpuRdData          host completion pulse and read data

module vram_readout_arbiter
  import vram_readout_arbiter_pkg::*;
#(
  parameter int COLS          = DEF_COLS,
  parameter int ROWS          = DEF_ROWS,
  parameter int LINES_PER_ROW = DEF_LINES_PER_ROW,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              lineStart,
  input  logic              frameStart,
  output logic [2:0]        readoutCount,
  output logic              active,
  output logic [ADDR_W-1:0] vramAddr,
  output logic              vramWe,
  output logic [7:0]        vramWrData,
  input  logic [7:0]        vramRdData,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [7:0]        cpuWrData,
  output logic              cpuAck,
  output logic [7:0]        cpuRdData
);

  readoutState_t state;
  logic          pending;

  logic              lastCol;
  logic              colStep;
  logic              windowEnd;
  logic              lineGo;
  logic              nextActive;
  logic [2:0]        nextCount;
  logic              hostSlot;
  logic              hostIssue;
  logic              charSlot;
  logic              attrSlot;
  logic [ADDR_W-1:0] charAddr;
  logic [ADDR_W-1:0] attrAddr;

  assign active    = (state == ST_READOUT);
  assign colStep   = active && (readoutCount == PH_ATTR_DATA);
  assign windowEnd = colStep && lastCol;
  assign lineGo    = lineStart && !active;
  assign cpuRdData = vramRdData;

  text_addr_gen #(
    .COLS          (COLS),
    .ROWS          (ROWS),
    .LINES_PER_ROW (LINES_PER_ROW),
    .ADDR_W        (ADDR_W)
  ) u_addrGen (
    .clk        (clk),
    .nrst       (nrst),
    .lineGo     (lineGo),
    .frameStart (frameStart),
    .colStep    (colStep),
    .lastCol    (lastCol),
    .charAddr   (charAddr),
    .attrAddr   (attrAddr)
  );

  // The VRAM controls are registered, so every slot decision is made on the
  // phase the outputs will show next cycle; that keeps the address aligned
  // with readoutCount as the pixel generator sees it.
  always_comb begin
    nextActive = active ? !windowEnd : lineStart;
    nextCount  = PH_IDLE;
    if (nextActive) begin
      nextCount = active ? readoutCount + 3'd1 : PH_HOST_A;
    end
    hostSlot  = !nextActive || (nextCount == PH_HOST_A) || (nextCount == PH_HOST_B);
    hostIssue = hostSlot && cpuReq && !pending;
    charSlot  = nextActive && (nextCount == PH_CHAR_ADDR);
    attrSlot  = nextActive && (nextCount == PH_ATTR_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      readoutCount <= PH_IDLE;
      vramAddr     <= '0;
      vramWe       <= 1'b0;
      vramWrData   <= '0;
      cpuAck       <= 1'b0;
      pending      <= 1'b0;
    end else begin
      state        <= nextActive ? ST_READOUT : ST_IDLE;
      readoutCount <= nextCount;

      // pending marks the issue cycle; the ack follows it, and a request
      // still held during the ack cycle counts as a fresh one.
      pending <= hostIssue;
      cpuAck  <= pending;

      vramWe <= 1'b0;
      if (hostIssue) begin
        vramAddr   <= cpuAddr;
        vramWe     <= cpuWe;
        vramWrData <= cpuWrData;
      end else if (charSlot) begin
        vramAddr <= charAddr;
      end else if (attrSlot) begin
        vramAddr <= attrAddr;
      end
    end
  end

endmodule

// File: tb/tb_vram_readout_arbiter.sv
// tb/tb_vram_readout_arbiter.sv - scoreboard bench for the VRAM readout arbiter

module tb_vram_readout_arbiter;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int LPR  = 16;
  localparam int AW   = 13;

  logic          clk = 1'b0;
  logic          nrst;
  logic          lineStart;
  logic          frameStart;
  logic [2:0]    readoutCount;
  logic          active;
  logic [AW-1:0] vramAddr;
  logic          vramWe;
  logic [7:0]    vramWrData;
  logic [7:0]    vramRdData;
  logic          cpuReq;
  logic          cpuWe;
  logic [AW-1:0] cpuAddr;
  logic [7:0]    cpuWrData;
  logic          cpuAck;
  logic [7:0]    cpuRdData;

  always #5 clk = ~clk;

  vram_readout_arbiter #(
    .COLS          (COLS),
    .ROWS          (ROWS),
    .LINES_PER_ROW (LPR),
    .ADDR_W        (AW)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .lineStart    (lineStart),
    .frameStart   (frameStart),
    .readoutCount (readoutCount),
    .active       (active),
    .vramAddr     (vramAddr),
    .vramWe       (vramWe),
    .vramWrData   (vramWrData),
    .vramRdData   (vramRdData),
    .cpuReq       (cpuReq),
    .cpuWe        (cpuWe),
    .cpuAddr      (cpuAddr),
    .cpuWrData    (cpuWrData),
    .cpuAck       (cpuAck),
    .cpuRdData    (cpuRdData)
  );

  // Single-port VRAM: read data appears one cycle after the address.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (vramWe) mem[vramAddr] <= vramWrData;
    vramRdData <= mem[vramAddr];
  end

  typedef struct packed {
    logic       isRead;
    logic [7:0] data;
  } ackExp_t;

  logic [AW-1:0] fetchQ [$];
  ackExp_t       ackQ [$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a fetch or an ack.
  initial begin
    logic [AW-1:0] ea;
    ackExp_t       ee;
    forever begin
      @(negedge clk);
      if (nrst && active && (readoutCount == 3'd2 || readoutCount == 3'd6)) begin
        if (fetchQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected actual=%0h required=none at %0t", vramAddr, $time);
        end else begin
          ea = fetchQ.pop_front();
          check("fetch_addr", 32'(vramAddr), 32'(ea));
          check("fetch_we", 32'(vramWe), 32'd0);
        end
      end
      if (cpuAck) begin
        if (ackQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected actual=1 required=0 at %0t", $time);
        end else begin
          ee = ackQ.pop_front();
          if (ee.isRead) check("cpu_rd_data", 32'(cpuRdData), 32'(ee.data));
        end
      end
    end
  end

  task automatic runLine(input int base, input bit withHost, input bit withFrame);
    int cyc;
    for (int c = 0; c < COLS; c++) begin
      fetchQ.push_back(AW'(base + 2 * c));
      fetchQ.push_back(AW'(base + 2 * c + 1));
    end
    lineStart = 1'b1;
    step(1);
    lineStart = 1'b0;
    cyc = 0;
    while (active && cyc < 64) begin
      check("rc_seq", 32'(readoutCount), 32'(cyc % 8));
      frameStart = withFrame && (cyc == 10);
      lineStart  = withFrame && (cyc == 12);
      if (withHost && cyc == 1) begin
        cpuReq  = 1'b1;
        cpuWe   = 1'b0;
        cpuAddr = AW'(13'h100);
        ackQ.push_back('{1'b1, 8'hA5});
      end
      if (withHost && cyc == 4) begin
        check("host_slot_addr", 32'(vramAddr), 32'h100);
        check("host_slot_we", 32'(vramWe), 32'd0);
      end
      if (withHost && cyc == 5) begin
        check("host_ack_phase", 32'(cpuAck), 32'd1);
        cpuReq = 1'b0;
      end
      step(1);
      cyc++;
    end
    frameStart = 1'b0;
    lineStart  = 1'b0;
    check("active_cycles", 32'(cyc), 32'd32);
    check("idle_count", 32'(readoutCount), 32'd7);
    step(1);
  endtask

  initial begin
    nrst = 1'b0; lineStart = 1'b0; frameStart = 1'b0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWrData = '0;
    step(3);
    check("rst_count", 32'(readoutCount), 32'd7);
    check("rst_active", 32'(active), 32'd0);
    check("rst_addr", 32'(vramAddr), 32'd0);
    check("rst_we", 32'(vramWe), 32'd0);
    check("rst_wrdata", 32'(vramWrData), 32'd0);
    check("rst_ack", 32'(cpuAck), 32'd0);
    nrst = 1'b1;
    step(2);

    // Idle host write then back-to-back read held through the ack cycle.
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = AW'(13'h100); cpuWrData = 8'hA5;
    ackQ.push_back('{1'b0, 8'h00});
    step(1);
    check("wr_issue_addr", 32'(vramAddr), 32'h100);
    check("wr_issue_we", 32'(vramWe), 32'd1);
    check("wr_issue_data", 32'(vramWrData), 32'hA5);
    check("wr_issue_noack", 32'(cpuAck), 32'd0);
    step(1);
    check("wr_ack", 32'(cpuAck), 32'd1);
    check("wr_ack_we", 32'(vramWe), 32'd0);
    cpuWe = 1'b0; cpuWrData = 8'h00;
    ackQ.push_back('{1'b1, 8'hA5});
    step(1);
    check("rd_issue_addr", 32'(vramAddr), 32'h100);
    check("rd_issue_we", 32'(vramWe), 32'd0);
    check("rd_issue_noack", 32'(cpuAck), 32'd0);
    step(1);
    check("rd_ack", 32'(cpuAck), 32'd1);
    cpuReq = 1'b0;
    step(2);
    check("no_extra_ack", 32'(cpuAck), 32'd0);

    // Lines 0..47 cover the row advance at line 16 and the ROWS wrap at
    // line 32; line 48 carries a mid-line frameStart and ignored lineStart.
    for (int l = 0; l <= 48; l++) begin
      runLine(((l / 16) % 2) * 8, (l == 1), (l == 48));
    end
    runLine(0, 1'b0, 1'b0);

    // Reset with a host read issued but not yet acknowledged.
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = AW'(13'h1FF);
    step(1);
    check("inflight_issue_addr", 32'(vramAddr), 32'h1FF);
    nrst = 1'b0;
    cpuReq = 1'b0;
    step(1);
    check("rst2_ack", 32'(cpuAck), 32'd0);
    check("rst2_count", 32'(readoutCount), 32'd7);
    check("rst2_active", 32'(active), 32'd0);
    check("rst2_addr", 32'(vramAddr), 32'd0);
    check("rst2_we", 32'(vramWe), 32'd0);
    check("rst2_wrdata", 32'(vramWrData), 32'd0);
    nrst = 1'b1;
    step(3);
    check("rst2_no_late_ack", 32'(cpuAck), 32'd0);

    check("fetchq_drained", 32'(fetchQ.size()), 32'd0);
    check("ackq_drained", 32'(ackQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
